ads42_spi_cfg: RTL and testbench

SPI register-programming engine for the ADS42 ADC. After reset it waits for ADC power-up, then writes a fixed init table and raises `o_ad_inital_over`. After that it services the calibration controller's 4-phase request (`i_ad_cal_start`/`o_ad_cal_over`) by writing the requested test-pattern mode and data-clock delay into the ADC. It sits directly downstream of the calibration controller and drives the ADC's serial interface pins.

---
 rtl/ads42_pkg.sv | 42 ++++
 rtl/ads42_spi_shift.sv | 131 +++++++++++++
 rtl/ads42_spi_cfg.sv | 188 ++++++++++++++++++
 tb/tb_ads42_spi_cfg.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads42_pkg.sv
// ads42_pkg: register map, init ROM, FSM states and frame helpers for the ADS42 SPI engine.
package ads42_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned INIT_N  = 4;

  localparam logic [6:0] REG_SWRST   = 7'h00;
  localparam logic [6:0] REG_TESTPAT = 7'h0F;
  localparam logic [6:0] REG_LVDS    = 7'h14;
  localparam logic [6:0] REG_CLKDLY  = 7'h12;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_READY,
    ST_CFG_MODE,
    ST_RB_MODE,
    ST_CFG_DLY,
    ST_RB_DLY,
    ST_DONE
  } state_e;

  // Build one frame {R/W, addr, data}; rd=0 is a write.
  function automatic logic [FRAME_W-1:0] mk_frame(input logic       rd,
                                                  input logic [6:0] addr,
                                                  input logic [7:0] data);
    return {rd, addr, data};
  endfunction

  // Power-up init table: soft reset, then default test pattern, LVDS and clock delay.
  function automatic logic [FRAME_W-1:0] init_rom(input logic [1:0] idx);
    logic [FRAME_W-1:0] w;
    case (idx)
      2'd0:    w = mk_frame(1'b0, REG_SWRST,   8'h01);
      2'd1:    w = mk_frame(1'b0, REG_TESTPAT, 8'h00);
      2'd2:    w = mk_frame(1'b0, REG_LVDS,    8'h00);
      default: w = mk_frame(1'b0, REG_CLKDLY,  8'h00);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ads42_spi_shift.sv
// ads42_spi_shift: sends one 16-bit frame in a 35*CLK_DIV-cycle slot; go_i may be
// re-asserted on the done_o cycle to chain frames with no gap.
// Read capture of data bits 7..0 is present when ADS42_SPI_READBACK_EN is defined.
module ads42_spi_shift
  import ads42_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               go_i,
  input  logic [FRAME_W-1:0] frame_i,
`ifdef ADS42_SPI_READBACK_EN
  input  logic               sdout_i,
  output logic [7:0]         rdata_o,
`endif
  output logic               done_o,
  output logic               sen_o,
  output logic               sclk_o,
  output logic               sdata_o
);

  localparam int unsigned      DIV_W       = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE     = DIV_W'(CLK_DIV - 2);
  localparam logic [5:0]       HP_RD_FIRST = 6'(FRAME_W);
  localparam logic [5:0]       HP_SEN_END  = 6'(2 * FRAME_W);
  localparam logic [5:0]       HP_LAST     = 6'(2 * FRAME_W + 2);

  logic               busy_q, busy_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0]         hp_q, hp_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic               sen_q, sen_d, sclk_q, sclk_d, sdata_q, sdata_d, done_q, done_d;
`ifdef ADS42_SPI_READBACK_EN
  logic [7:0]         rdata_q, rdata_d;
`endif

  // Half-period sequencer: hp 0 lead-in low, hp 1..32 bit high/low, hp 33..34 SEN-high gap.
  always_comb begin
    busy_d  = busy_q;
    div_d   = div_q;
    hp_d    = hp_q;
    sh_d    = sh_q;
    sen_d   = sen_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    done_d  = 1'b0;
`ifdef ADS42_SPI_READBACK_EN
    rdata_d = rdata_q;
`endif
    if (go_i) begin
      busy_d  = 1'b1;
      div_d   = '0;
      hp_d    = '0;
      sh_d    = {frame_i[FRAME_W-2:0], 1'b0};
      sen_d   = 1'b0;
      sclk_d  = 1'b0;
      sdata_d = frame_i[FRAME_W-1];
`ifdef ADS42_SPI_READBACK_EN
      rdata_d = '0;
`endif
    end else if (busy_q) begin
      done_d = (hp_q == HP_LAST) && (div_q == DIV_PRE);
      if (div_q == DIV_LAST) begin
        div_d = '0;
        hp_d  = hp_q + 6'd1;
        if (hp_q < HP_SEN_END) begin
          sclk_d = ~hp_q[0];
          if (hp_q[0]) begin
            sdata_d = sh_q[FRAME_W-1];
            sh_d    = {sh_q[FRAME_W-2:0], 1'b0};
          end
`ifdef ADS42_SPI_READBACK_EN
          else if (hp_q >= HP_RD_FIRST) begin
            rdata_d = {rdata_q[6:0], sdout_i};
          end
`endif
        end
        if (hp_q == HP_SEN_END) begin
          sen_d   = 1'b1;
          sdata_d = 1'b0;
        end
        if (hp_q == HP_LAST) begin
          busy_d = 1'b0;
          hp_d   = '0;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Serializer registers; pins idle with SEN high, SCLK and SDATA low.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      div_q   <= '0;
      hp_q    <= '0;
      sh_q    <= '0;
      sen_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADS42_SPI_READBACK_EN
      rdata_q <= '0;
`endif
    end else begin
      busy_q  <= busy_d;
      div_q   <= div_d;
      hp_q    <= hp_d;
      sh_q    <= sh_d;
      sen_q   <= sen_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      done_q  <= done_d;
`ifdef ADS42_SPI_READBACK_EN
      rdata_q <= rdata_d;
`endif
    end
  end

  assign done_o  = done_q;
  assign sen_o   = sen_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;
`ifdef ADS42_SPI_READBACK_EN
  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/ads42_spi_cfg.sv
// ads42_spi_cfg: ADS42 power-up init and calibration-request SPI programming engine.
// Define ADS42_SPI_READBACK_EN to read back and verify each calibration write.
module ads42_spi_cfg
  import ads42_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned RST_WAIT = 1000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  output logic       o_ad_inital_over,
  input  logic [3:0] i_ad_mode,
  input  logic [2:0] i_ad_dly,
  input  logic       i_ad_cal_start,
  output logic       o_ad_cal_over,
`ifdef ADS42_SPI_READBACK_EN
  input  logic       i_spi_sdout,
  output logic       o_spi_err,
`endif
  output logic       o_spi_sen,
  output logic       o_spi_sclk,
  output logic       o_spi_sdata
);

  localparam int unsigned      CNT_W     = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT - 1);

  state_e             st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [2:0]         dly_q, dly_d;
  logic               init_over_q, init_over_d, cal_over_q, cal_over_d;
  logic               go_c, done;
  logic [FRAME_W-1:0] frame_c;
`ifdef ADS42_SPI_READBACK_EN
  logic [3:0]         mode_q, mode_d;
  logic               err_q, err_d;
  logic [7:0]         rdata;
`endif

  // Sequencer: next frame is launched on the done cycle of the previous one.
  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    init_over_d = init_over_q;
    cal_over_d  = (st_q == ST_DONE);
    go_c        = 1'b0;
    frame_c     = '0;
`ifdef ADS42_SPI_READBACK_EN
    mode_d      = mode_q;
    err_d       = err_q;
`endif
    case (st_q)
      ST_PWRUP: begin
        if (cnt_q == WAIT_LAST) begin
          st_d    = ST_INIT;
          idx_d   = 2'd0;
          go_c    = 1'b1;
          frame_c = init_rom(2'd0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (done) begin
          if (idx_q == 2'(INIT_N - 1)) begin
            st_d        = ST_READY;
            init_over_d = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            go_c    = 1'b1;
            frame_c = init_rom(idx_q + 2'd1);
          end
        end
      end
      ST_READY: begin
        // Wait for over to drop so one level request is never serviced twice.
        if (i_ad_cal_start && !cal_over_q) begin
          st_d    = ST_CFG_MODE;
          dly_d   = i_ad_dly;
          go_c    = 1'b1;
          frame_c = mk_frame(1'b0, REG_TESTPAT, {i_ad_mode, 4'h0});
`ifdef ADS42_SPI_READBACK_EN
          mode_d  = i_ad_mode;
`endif
        end
      end
      ST_CFG_MODE: begin
        if (done) begin
          go_c = 1'b1;
`ifdef ADS42_SPI_READBACK_EN
          st_d    = ST_RB_MODE;
          frame_c = mk_frame(1'b1, REG_TESTPAT, 8'h00);
`else
          st_d    = ST_CFG_DLY;
          frame_c = mk_frame(1'b0, REG_CLKDLY, {5'b0, dly_q});
`endif
        end
      end
`ifdef ADS42_SPI_READBACK_EN
      ST_RB_MODE: begin
        if (done) begin
          if (rdata != {mode_q, 4'h0}) err_d = 1'b1;
          st_d    = ST_CFG_DLY;
          go_c    = 1'b1;
          frame_c = mk_frame(1'b0, REG_CLKDLY, {5'b0, dly_q});
        end
      end
`endif
      ST_CFG_DLY: begin
        if (done) begin
`ifdef ADS42_SPI_READBACK_EN
          st_d    = ST_RB_DLY;
          go_c    = 1'b1;
          frame_c = mk_frame(1'b1, REG_CLKDLY, 8'h00);
`else
          st_d    = ST_DONE;
`endif
        end
      end
`ifdef ADS42_SPI_READBACK_EN
      ST_RB_DLY: begin
        if (done) begin
          if (rdata != {5'b0, dly_q}) err_d = 1'b1;
          st_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (!i_ad_cal_start) st_d = ST_READY;
      end
      default: st_d = ST_PWRUP;
    endcase
  end

  // State and status registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_PWRUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      dly_q       <= '0;
      init_over_q <= 1'b0;
      cal_over_q  <= 1'b0;
`ifdef ADS42_SPI_READBACK_EN
      mode_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      init_over_q <= init_over_d;
      cal_over_q  <= cal_over_d;
`ifdef ADS42_SPI_READBACK_EN
      mode_q      <= mode_d;
      err_q       <= err_d;
`endif
    end
  end

  ads42_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .go_i    (go_c),
    .frame_i (frame_c),
`ifdef ADS42_SPI_READBACK_EN
    .sdout_i (i_spi_sdout),
    .rdata_o (rdata),
`endif
    .done_o  (done),
    .sen_o   (o_spi_sen),
    .sclk_o  (o_spi_sclk),
    .sdata_o (o_spi_sdata)
  );

  assign o_ad_inital_over = init_over_q;
  assign o_ad_cal_over    = cal_over_q;
`ifdef ADS42_SPI_READBACK_EN
  assign o_spi_err        = err_q;
`endif

endmodule

// File: tb/tb_ads42_spi_cfg.sv
// tb_ads42_spi_cfg: randomized requests against a frame-list reference model with a pin-level SPI decoder.
`timescale 1ns/1ps
module tb_ads42_spi_cfg;

  localparam int D      = 4;
  localparam int RW     = 1000;
  localparam int SLOT   = 35 * D;
  localparam int INIT_T = RW + 4 * SLOT;
`ifdef ADS42_SPI_READBACK_EN
  localparam int REQ_FR = 4;
`else
  localparam int REQ_FR = 2;
`endif
  localparam int LAT    = REQ_FR * SLOT + 1;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       init_over, cal_over, spi_sen, spi_sclk, spi_sdata, cal_start;
  logic [3:0] ad_mode;
  logic [2:0] ad_dly;
`ifdef ADS42_SPI_READBACK_EN
  logic       spi_sdout, spi_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: ordered list of frames the ADC must see, with required start cycle (-1: any).
  logic [15:0] exp_word[$];
  int          exp_fall[$];
  logic [15:0] init_words [4] = '{16'h0001, 16'h0F00, 16'h1400, 16'h1200};
  logic [3:0]  rb_mode = '0;
  logic [2:0]  rb_dly = '0;
  bit          rb_corrupt = 1'b0;
  bit          exp_err = 1'b0;

  // Decoder state
  bit          in_fr = 1'b0, prev_sen = 1'b1, prev_sclk = 1'b0;
  logic [15:0] m_word, ew;
  int          m_nb, m_low, m_fall, ef;
  logic [7:0]  rv;

  ads42_spi_cfg #(.CLK_DIV(D), .RST_WAIT(RW)) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .o_ad_inital_over (init_over),
    .i_ad_mode        (ad_mode),
    .i_ad_dly         (ad_dly),
    .i_ad_cal_start   (cal_start),
    .o_ad_cal_over    (cal_over),
`ifdef ADS42_SPI_READBACK_EN
    .i_spi_sdout      (spi_sdout),
    .o_spi_err        (spi_err),
`endif
    .o_spi_sen        (spi_sen),
    .o_spi_sclk       (spi_sclk),
    .o_spi_sdata      (spi_sdata)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_init();
    for (int k = 0; k < 4; k++) begin
      exp_word.push_back(init_words[k]);
      exp_fall.push_back(RW + k * SLOT);
    end
  endtask

  task automatic push_req(input logic [3:0] m, input logic [2:0] d);
    exp_word.push_back({1'b0, 7'h0F, m, 4'h0});      exp_fall.push_back(-1);
`ifdef ADS42_SPI_READBACK_EN
    exp_word.push_back({1'b1, 7'h0F, 8'h00});        exp_fall.push_back(-1);
`endif
    exp_word.push_back({1'b0, 7'h12, 5'b0, d});      exp_fall.push_back(-1);
`ifdef ADS42_SPI_READBACK_EN
    exp_word.push_back({1'b1, 7'h12, 8'h00});        exp_fall.push_back(-1);
`endif
  endtask

  task automatic chk_reset_outs(input string where);
    chk({where, "_sen"},       32'(spi_sen),   32'd1);
    chk({where, "_sclk"},      32'(spi_sclk),  32'd0);
    chk({where, "_sdata"},     32'(spi_sdata), 32'd0);
    chk({where, "_init_over"}, 32'(init_over), 32'd0);
    chk({where, "_cal_over"},  32'(cal_over),  32'd0);
`ifdef ADS42_SPI_READBACK_EN
    chk({where, "_err"},       32'(spi_err),   32'd0);
`endif
  endtask

  task automatic wait_init(output int t);
    int k = 0;
    while (!init_over && k < INIT_T + 100) begin
      @(negedge sys_clk);
      k++;
    end
    t = cyc;
    chk("init_over_cycle", (t >= INIT_T - 1 && t <= INIT_T + 1) ? 32'(INIT_T) : 32'(t), 32'(INIT_T));
  endtask

  task automatic drop_and_check_fall();
    int k = 0;
    bit hi = 1'b1;
    cal_start = 1'b0;
    while (hi && k < 10) begin
      @(posedge sys_clk);
      k++;
      @(negedge sys_clk);
      hi = cal_over;
    end
    chk("over_fall_delay", 32'(k - 1), 32'd1);
`ifdef ADS42_SPI_READBACK_EN
    chk("err_after_drop", 32'(spi_err), 32'(exp_err));
`endif
  endtask

  task automatic do_req(input logic [3:0] m, input logic [2:0] d, input bit drop_early, input bit corrupt);
    int k = 0;
    bit seen = 1'b0;
    ad_mode = m;  ad_dly = d;
    rb_mode = m;  rb_dly = d;  rb_corrupt = corrupt;
    if (corrupt && d != 3'd2) exp_err = 1'b1;
    push_req(m, d);
    cal_start = 1'b1;
    while (!seen && k < LAT + 50) begin
      @(posedge sys_clk);
      k++;
      @(negedge sys_clk);
      if (k == 5) begin
        ad_mode = 4'($urandom);
        ad_dly  = 3'($urandom);
      end
      if (drop_early && k == 100) cal_start = 1'b0;
      seen = cal_over;
    end
    chk("req_latency", 32'(k - 1), 32'(LAT));
    chk("req_frames_left", 32'(exp_word.size()), 32'd0);
`ifdef ADS42_SPI_READBACK_EN
    chk("err_at_over", 32'(spi_err), 32'(exp_err));
`endif
    if (drop_early) begin
      @(negedge sys_clk);
      chk("over_one_cycle", 32'(cal_over), 32'd0);
    end else begin
      repeat ($urandom_range(1, 6)) begin
        @(negedge sys_clk);
        chk("over_hold", 32'(cal_over), 32'd1);
      end
      drop_and_check_fall();
    end
    repeat ($urandom_range(1, 20)) @(negedge sys_clk);
  endtask

  // Pin-level SPI decoder: rebuild each frame from SCLK rising edges and compare with the model list.
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      in_fr     = 1'b0;
      prev_sen  = 1'b1;
      prev_sclk = 1'b0;
    end else begin
      if (prev_sen && !spi_sen) begin
        in_fr  = 1'b1;
        m_word = '0;
        m_nb   = 0;
        m_low  = 0;
        m_fall = cyc;
      end
      if (in_fr) begin
        if (!prev_sclk && spi_sclk) begin
          m_word = {m_word[14:0], spi_sdata};
          m_nb++;
        end
        if (!spi_sen) begin
          m_low++;
        end else begin
          in_fr = 1'b0;
          if (exp_word.size() == 0) begin
            chk("frame_unexpected", 32'(m_word), 32'hFFFF_FFFF);
          end else begin
            ew = exp_word.pop_front();
            ef = exp_fall.pop_front();
            chk("frame_word", 32'(m_word), 32'(ew));
            chk("sen_low_len", 32'(m_low), 32'(33 * D));
            chk("frame_bits", 32'(m_nb), 32'd16);
            chk("sclk_idle_at_end", 32'(spi_sclk), 32'd0);
            if (ef >= 0) chk("frame_start_cycle", 32'(m_fall), 32'(ef));
          end
        end
      end
`ifdef ADS42_SPI_READBACK_EN
      // ADC side of a read: present the register value ahead of each data-bit rising edge.
      if (in_fr && !spi_sen && !spi_sclk && m_nb >= 8 && m_nb < 16) begin
        if (m_word[6:0] == 7'h0F) rv = {rb_mode, 4'h0};
        else                      rv = rb_corrupt ? 8'h02 : {5'b0, rb_dly};
        spi_sdout = m_word[7] ? rv[15 - m_nb] : 1'b0;
      end else begin
        spi_sdout = 1'b0;
      end
`endif
      prev_sen  = spi_sen;
      prev_sclk = spi_sclk;
    end
  end

  initial begin
    int t_init;
    int k;
    bit seen;
    rst_n = 1'b0;
    cal_start = 1'b0;
    ad_mode = '0;
    ad_dly = '0;
`ifdef ADS42_SPI_READBACK_EN
    spi_sdout = 1'b0;
`endif
    repeat (4) @(negedge sys_clk);
    chk_reset_outs("rst");

    // Request held high through reset: must wait for the whole init table.
    ad_mode = 4'($urandom);
    ad_dly  = 3'($urandom);
    rb_mode = ad_mode;
    rb_dly  = ad_dly;
    push_init();
    push_req(ad_mode, ad_dly);
    cal_start = 1'b1;
    @(negedge sys_clk);
    rst_n = 1'b1;
    wait_init(t_init);
    chk("held_cfg_pending", 32'(exp_word.size()), 32'(REQ_FR));
    k = 0;
    seen = 1'b0;
    while (!seen && k < LAT + 50) begin
      @(negedge sys_clk);
      k++;
      seen = cal_over;
    end
    chk("held_over_cycle", 32'(cyc), 32'(t_init + 1 + LAT));
    chk("held_frames_left", 32'(exp_word.size()), 32'd0);
    drop_and_check_fall();
    repeat (5) @(negedge sys_clk);

    // Directed request, then randomized ones (one with start dropped mid-write).
    do_req(4'b0100, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_req(4'($urandom), 3'($urandom), (i == 2), 1'b0);
    end

    // Reset in the middle of the second frame of a request.
    ad_mode = 4'($urandom);
    ad_dly  = 3'($urandom);
    rb_mode = ad_mode;
    rb_dly  = ad_dly;
    push_req(ad_mode, ad_dly);
    cal_start = 1'b1;
    repeat (SLOT + 45) @(negedge sys_clk);
    chk("mid_sen_low", 32'(spi_sen), 32'd0);
    chk("mid_sclk_high", 32'(spi_sclk), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    exp_word.delete();
    exp_fall.delete();
    exp_err = 1'b0;
    cal_start = 1'b0;
    repeat (3) @(negedge sys_clk);
    push_init();
    rst_n = 1'b1;
    wait_init(t_init);
    chk("reinit_frames_left", 32'(exp_word.size()), 32'd0);
    repeat (3) @(negedge sys_clk);
    do_req(4'($urandom), 3'($urandom), 1'b0, 1'b0);

`ifdef ADS42_SPI_READBACK_EN
    // ADC answers 0x02 for a dly=3 write: sticky error, over still completes.
    do_req(4'($urandom), 3'd3, 1'b0, 1'b1);
    chk("err_sticky", 32'(spi_err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
